// File: rtl/multicycle_pkg.sv
// multicycle_pkg: states, opcodes and control encodings.
// Macro MULTICYCLE_CTRL_BNE_EN makes opcode 5 (bne) legal.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_FUNCT = 3'd2,
    ALU_SLT   = 3'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'd0,
    SRCB_4       = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } src_b_e;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'd0,
    PCS_ALUOUT = 2'd1,
    PCS_JUMP   = 2'd2
  } pc_src_e;

  typedef struct packed {
    logic    pc_write;
    logic    pc_write_cond;
    logic    branch_ne;
    pc_src_e pc_source;
    logic    i_or_d;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    reg_write;
    logic    alu_src_a;
    src_b_e  alu_src_b;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_t;

  // First execute state for an opcode; FETCH marks it illegal.
  function automatic state_e dispatch(
    input logic [5:0] op
  );
    unique case (op)
      OP_RTYPE:        dispatch = S_R_EXEC;
      OP_J:            dispatch = S_JUMP;
      OP_BEQ:          dispatch = S_BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
      OP_BNE:          dispatch = S_BRANCH;
`endif
      OP_ADDI,
      OP_SLTI:         dispatch = S_I_EXEC;
      OP_LW,
      OP_SW:           dispatch = S_MEM_ADDR;
      default:         dispatch = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state/ready/opcode -> control word.
// Ports: i_state, i_ready, i_op in; o_ctrl out. Macro MULTICYCLE_CTRL_BNE_EN.
module multicycle_ctrl_decode
  import multicycle_pkg::*;
(
  input  state_e     i_state,
  input  logic       i_ready,
  input  logic [5:0] i_op,
  output ctrl_t      o_ctrl
);

  logic w_is_bne;

`ifdef MULTICYCLE_CTRL_BNE_EN
  assign w_is_bne = (i_op == OP_BNE);
`else
  assign w_is_bne = 1'b0;
`endif

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_4;
        // IR and PC load only when the fetch completes.
        o_ctrl.ir_write  = i_ready;
        o_ctrl.pc_write  = i_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.illegal   = (dispatch(i_op) == S_FETCH);
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCS_ALUOUT;
        o_ctrl.branch_ne     = w_is_bne;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCS_JUMP;
      end
      S_I_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = (i_op == OP_SLTI) ?
                           ALU_SLT : ALU_ADD;
      end
      S_I_WB: begin
        o_ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: state register, sequencing and retired counter.
// Drives datapath controls; macro MULTICYCLE_CTRL_BNE_EN enables bne.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [OP_W-1:0]  instr_op_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             branch_ne_o,
  output logic [1:0]       pc_source_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             illegal_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e           r_state;
  logic [CNT_W-1:0] r_retired;
  logic [5:0]       w_op;
  ctrl_t            w_ctrl;
  ctrl_t            w_out;
  logic             w_retire;

  assign w_op = 6'(instr_op_i);

  multicycle_ctrl_decode u_decode (
    .i_state (r_state),
    .i_ready (mem_ready_i),
    .i_op    (w_op),
    .o_ctrl  (w_ctrl)
  );

  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEM_WB,
      S_R_WB,
      S_BRANCH,
      S_JUMP,
      S_I_WB:   w_retire = 1'b1;
      S_MEM_WR: w_retire = mem_ready_i;
      default:  w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      if (w_retire)
        r_retired <= r_retired + CNT_W'(1);
      case (r_state)
        S_FETCH:
          if (mem_ready_i)
            r_state <= S_DECODE;
        S_DECODE:
          r_state <= dispatch(w_op);
        S_MEM_ADDR:
          r_state <= (w_op == OP_LW) ?
                     S_MEM_RD : S_MEM_WR;
        S_MEM_RD:
          if (mem_ready_i)
            r_state <= S_MEM_WB;
        S_MEM_WR:
          if (mem_ready_i)
            r_state <= S_FETCH;
        S_R_EXEC: r_state <= S_R_WB;
        S_I_EXEC: r_state <= S_I_WB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Everything reads as zero while reset is held.
  assign w_out = rst_i ? '0 : w_ctrl;

  assign pc_write_o      = w_out.pc_write;
  assign pc_write_cond_o = w_out.pc_write_cond;
  assign branch_ne_o     = w_out.branch_ne;
  assign pc_source_o     = w_out.pc_source;
  assign i_or_d_o        = w_out.i_or_d;
  assign mem_read_o      = w_out.mem_read;
  assign mem_write_o     = w_out.mem_write;
  assign ir_write_o      = w_out.ir_write;
  assign reg_dst_o       = w_out.reg_dst;
  assign mem_to_reg_o    = w_out.mem_to_reg;
  assign reg_write_o     = w_out.reg_write;
  assign alu_src_a_o     = w_out.alu_src_a;
  assign alu_src_b_o     = w_out.alu_src_b;
  assign alu_op_o        = w_out.alu_op;
  assign illegal_o       = w_out.illegal;
  assign state_o         = rst_i ? 4'd0 : r_state;
  assign retired_o       = rst_i ? '0 : r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl against an instruction-level model.
// Honours MULTICYCLE_CTRL_BNE_EN to know whether opcode 5 is legal.
module tb_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic        rdy;
  logic        pc_write_o, pc_write_cond_o, branch_ne_o;
  logic [1:0]  pc_source_o;
  logic        i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
  logic        reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic [2:0]  alu_op_o;
  logic        illegal_o;
  logic [3:0]  state_o;
  logic [31:0] retired_o;

  multicycle_ctrl #(.OP_W(6), .CNT_W(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .instr_op_i      (op),
    .mem_ready_i     (rdy),
    .pc_write_o      (pc_write_o),
    .pc_write_cond_o (pc_write_cond_o),
    .branch_ne_o     (branch_ne_o),
    .pc_source_o     (pc_source_o),
    .i_or_d_o        (i_or_d_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .ir_write_o      (ir_write_o),
    .reg_dst_o       (reg_dst_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .reg_write_o     (reg_write_o),
    .alu_src_a_o     (alu_src_a_o),
    .alu_src_b_o     (alu_src_b_o),
    .alu_op_o        (alu_op_o),
    .illegal_o       (illegal_o),
    .state_o         (state_o),
    .retired_o       (retired_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit       pcw, pcwc, bne;
    bit [1:0] pcs;
    bit       iord, mrd, mwr, irw, rdst, m2r, rw, sa;
    bit [1:0] sb;
    bit [2:0] aop;
    bit       ill;
  } word_t;

  int total = 0;
  int bad = 0;
  int model_ret = 0;
  int cyc = 0;
  int trace[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic bit legal(input int o);
    return o == 0 || o == 2 || o == 4 || o == 8 ||
           o == 10 || o == 35 || o == 43 ||
           (BNE_EN && o == 5);
  endfunction

  // Ordered list of steps an opcode walks through, from the opcode table.
  task automatic steps(input int o, output int q[$]);
    q = '{0, 1};
    if (o == 0)                 q = '{0, 1, 6, 7};
    else if (o == 2)            q = '{0, 1, 9};
    else if (o == 4)            q = '{0, 1, 8};
    else if (o == 5 && BNE_EN)  q = '{0, 1, 8};
    else if (o == 8 || o == 10) q = '{0, 1, 10, 11};
    else if (o == 35)           q = '{0, 1, 2, 3, 4};
    else if (o == 43)           q = '{0, 1, 2, 5};
  endtask

  // Per-step control table.
  function automatic word_t exp_word(input int st,
                                     input bit r,
                                     input int o);
    word_t w;
    w = '0;
    case (st)
      0:  begin w.mrd = 1; w.sb = 1; w.irw = r; w.pcw = r; end
      1:  begin w.sb = 3; w.ill = !legal(o); end
      2:  begin w.sa = 1; w.sb = 2; end
      3:  begin w.mrd = 1; w.iord = 1; end
      4:  begin w.rw = 1; w.m2r = 1; end
      5:  begin w.mwr = 1; w.iord = 1; end
      6:  begin w.sa = 1; w.aop = 2; end
      7:  begin w.rw = 1; w.rdst = 1; end
      8:  begin w.sa = 1; w.aop = 1; w.pcwc = 1;
                w.pcs = 1; w.bne = (o == 5); end
      9:  begin w.pcw = 1; w.pcs = 2; end
      10: begin w.sa = 1; w.sb = 2;
                w.aop = (o == 10) ? 3'd3 : 3'd0; end
      11: w.rw = 1;
      default: ;
    endcase
    return w;
  endfunction

  task automatic cycle(input int st, input bit r,
                       input int o, input bit rs);
    word_t ew, dw;
    @(posedge clk);
    #1;
    rst = rs;
    rdy = r;
    op  = 6'(o);
    @(negedge clk);
    cyc++;
    dw = {pc_write_o, pc_write_cond_o, branch_ne_o,
          pc_source_o, i_or_d_o, mem_read_o,
          mem_write_o, ir_write_o, reg_dst_o,
          mem_to_reg_o, reg_write_o, alu_src_a_o,
          alu_src_b_o, alu_op_o, illegal_o};
    ew = rs ? word_t'(0) : exp_word(st, r, o);
    chk("ctrl", 32'(dw), 32'(ew));
    chk("state", 32'(state_o), rs ? 32'd0 : 32'(st));
    chk("retired", retired_o,
        rs ? 32'd0 : 32'(model_ret));
    trace.push_back(int'(state_o));
  endtask

  // Runs one instruction; abort >= 0 applies reset at that cycle index.
  task automatic run_instr(input int o, input int wf,
                           input int wm, input int abort,
                           output int n);
    int q[$];
    int reps;
    bit memst;
    bit r;
    steps(o, q);
    n = 0;
    trace.delete();
    foreach (q[i]) begin
      memst = (q[i] == 0 || q[i] == 3 || q[i] == 5);
      reps = (q[i] == 0) ? wf : (memst ? wm : 0);
      for (int k = 0; k <= reps; k++) begin
        r = memst ? (k == reps) : 1'($urandom_range(0, 1));
        if (n == abort) begin
          cycle(q[i], 1'b0, o, 1'b1);
          model_ret = 0;
          return;
        end
        cycle(q[i], r,
              (q[i] == 0) ? int'($urandom_range(0, 63)) : o,
              1'b0);
        n++;
      end
    end
    if (legal(o))
      model_ret++;
  endtask

  int n;
  int ops[12] = '{0, 2, 4, 5, 8, 10, 35, 43, 63, 1, 3, 17};
  int exp_r[4] = '{0, 1, 6, 7};
  int exp_l[7] = '{0, 1, 2, 3, 3, 3, 4};

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    op  = 6'd0;
    #1;
    chk("rst_pre_edge_mrd", 32'(mem_read_o), 32'd0);
    repeat (3) cycle(0, 1'b1, 0, 1'b1);

    run_instr(0, 0, 0, -1, n);
    chk("r_cycles", n, 4);
    chk("r_trace_len", trace.size(), 4);
    foreach (exp_r[i]) chk("r_trace", trace[i], exp_r[i]);

    run_instr(35, 0, 2, -1, n);
    chk("lw_wait_cycles", n, 7);
    foreach (exp_l[i]) chk("lw_trace", trace[i], exp_l[i]);

    run_instr(35, 0, 0, -1, n);
    chk("lw_cycles", n, 5);
    run_instr(43, 0, 0, -1, n);
    chk("sw_cycles", n, 4);
    run_instr(8, 0, 0, -1, n);
    chk("addi_cycles", n, 4);
    run_instr(10, 1, 0, -1, n);
    chk("slti_fetchwait_cycles", n, 5);
    run_instr(2, 0, 0, -1, n);
    chk("j_cycles", n, 3);
    run_instr(4, 0, 0, -1, n);
    chk("beq_cycles", n, 3);
    run_instr(5, 0, 0, -1, n);
    chk("bne_cycles", n, BNE_EN ? 3 : 2);
    chk("retired_lit", 32'(model_ret), BNE_EN ? 32'd9 : 32'd8);
    run_instr(63, 0, 0, -1, n);
    chk("ill_cycles", n, 2);
    chk("retired_after_ill", 32'(model_ret),
        BNE_EN ? 32'd9 : 32'd8);

    for (int t = 0; t < 80; t++)
      run_instr(ops[$urandom_range(0, 11)],
                $urandom_range(0, 3),
                $urandom_range(0, 3), -1, n);

    // sw: fetch wait 1, MEM_WR stuck; reset on second MEM_WR cycle.
    run_instr(43, 1, 3, 5, n);
    chk("abort_at", n, 5);
    cycle(0, 1'b0, 0, 1'b1);
    chk("abort_no_mwr", 32'(mem_write_o), 32'd0);
    run_instr(0, 0, 0, -1, n);
    chk("abort_first_state", trace[0], 0);
    chk("abort_retired", 32'(model_ret), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Finite-state controller that sequences a multi-cycle MIPS-subset datapath: one shared memory, IR/MDR/A/B/ALUOut holding registers, one ALU, one register file. Each instruction is broken into 3–5 steps, and the controller drives every mux select and write enable per step. Memory accesses use a ready handshake so wait states can be inserted. It replaces the per-instruction combinational decoder of the single-cycle core and feeds the existing ALU control block through `alu_op_o`.

## Interface
- `OP_W`, 6: opcode width (`instr_op_i`).
- `CNT_W`, 32: width of retired-instruction counter.
- `clk_i` input 1: clock; all state changes on rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `instr_op_i` input `OP_W`: opcode field of the IR (bits 31:26), valid from DECODE onward.
- `mem_ready_i` input 1: memory has completed the current read/write this cycle.
- `pc_write_o` output 1: unconditional PC load.
- `pc_write_cond_o` output 1: PC load qualified by ALU zero (or !zero for bne).
- `branch_ne_o` output 1: invert zero qualification (bne).
- `pc_source_o` output 2: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `i_or_d_o` output 1: memory address source, 0 = PC, 1 = ALUOut.
- `mem_read_o`, `mem_write_o` output 1 each: memory request strobes.
- `ir_write_o` output 1: load IR.
- `reg_dst_o` output 1: 0 = rt, 1 = rd.
- `mem_to_reg_o` output 1: 0 = ALUOut, 1 = MDR.
- `reg_write_o` output 1: register file write.
- `alu_src_a_o` output 1: 0 = PC, 1 = A.
- `alu_src_b_o` output 2: 0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2.
- `alu_op_o` output 3: 0 = add, 1 = sub, 2 = R-type (use funct), 3 = slt.
- `illegal_o` output 1: one-cycle pulse on an unsupported opcode.
- `state_o` output 4: current state encoding, for debug.
- `retired_o` output `CNT_W`: count of completed instructions.

## Operation
- Opcodes: R=0, j=2, beq=4, bne=5 (configurable), addi=8, slti=10, lw=35, sw=43.
- States (4-bit):
  - FETCH=0: mem_read, i_or_d=0, srcA=PC, srcB=4, alu_op=add, pc_source=0. `ir_write_o` and `pc_write_o` assert only in the cycle `mem_ready_i`=1, then go to DECODE. Otherwise hold FETCH.
  - DECODE=1: srcA=PC, srcB=3, alu_op=add (branch target into ALUOut). Dispatch on opcode.
  - MEM_ADDR=2 (lw/sw): srcA=A, srcB=2, add. Go to MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD=3: mem_read, i_or_d=1. Hold until ready, then go to MEM_WB.
  - MEM_WB=4: reg_write, reg_dst=0, mem_to_reg=1. Go to FETCH.
  - MEM_WR=5: mem_write, i_or_d=1. Hold until ready, then go to FETCH.
  - R_EXEC=6: srcA=A, srcB=0, alu_op=R. Go to R_WB.
  - R_WB=7: reg_write, reg_dst=1, mem_to_reg=0. Go to FETCH.
  - BRANCH=8: srcA=A, srcB=0, sub, pc_write_cond, pc_source=1; branch_ne for bne. Go to FETCH.
  - JUMP=9: pc_write, pc_source=2. Go to FETCH.
  - I_EXEC=10: srcA=A, srcB=2, alu_op=add (addi) or slt (slti). Go to I_WB.
  - I_WB=11: reg_write, reg_dst=0, mem_to_reg=0. Go to FETCH.
- Unused encodings 12–15: next state FETCH, all outputs 0.
- Illegal opcode in DECODE: pulse `illegal_o`, go to FETCH with no write, `retired_o` unchanged.
- `retired_o` increments by 1 on every transition from MEM_WB, MEM_WR(ready), R_WB, BRANCH, JUMP or I_WB into FETCH. It wraps at 2^CNT_W.
- Any output not listed for a state is 0.

## Timing
- Moore outputs decode from the state register. Exceptions: `ir_write_o` and `pc_write_o` in FETCH are qualified by `mem_ready_i`.
- Cycles with zero wait states: beq/bne/j = 3, R/addi/slti/sw = 4, lw = 5. Each wait state adds 1 cycle in FETCH, MEM_RD or MEM_WR.
- `mem_read_o`/`mem_write_o` stay high and address select stays stable until the ready cycle inclusive.
- `mem_ready_i` in a non-memory state is ignored.
- Reset: while `rst_i`=1, all outputs are 0. On the first edge with `rst_i` high, state becomes FETCH and `retired_o`=0.
- Reset mid-instruction abandons the instruction: no register, PC or memory write, and any pending memory request is dropped.

## Configuration
- `MULTICYCLE_CTRL_BNE_EN` defined: opcode 5 goes to BRANCH with `branch_ne_o`=1.
- Not defined: opcode 5 is illegal, and `branch_ne_o` is tied to 0.

## Structure
- Package `multicycle_pkg`: state enum, opcode constants, `alu_op` and `alu_src_b`/`pc_source` encodings.
- Sub-module `multicycle_ctrl_decode`: purely combinational state (+ready, opcode) → control word. The top holds the state register, next-state logic and counter.

## Test plan
- Reset held 3 cycles, then released with `mem_ready_i`=1 → outputs 0 during reset; `state_o`=0, `mem_read_o`=1 on release; `retired_o`=0.
- R-type (op 0), ready always 1 → states 0,1,6,7,0; `reg_write_o`=1 only in state 7 with `reg_dst_o`=1; `retired_o` 0→1.
- lw (op 35) with ready low for 2 cycles in MEM_RD → states 0,1,2,3,3,3,4,0 (8 cycles); `i_or_d_o`=1 throughout MEM_RD; `mem_to_reg_o`=1 in state 4.
- beq (op 4) then bne (op 5), with and without `MULTICYCLE_CTRL_BNE_EN` → BRANCH with `branch_ne_o` 0 then 1 when enabled; otherwise op 5 pulses `illegal_o`, `retired_o` increments once.
- Opcode 63 → `illegal_o` for 1 cycle, returns to FETCH, no write strobe in any cycle.
- `rst_i` asserted during MEM_WR with ready low → no `mem_write_o` after the reset edge, state 0, `retired_o`=0.
